// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte plus odd parity and stop bit out on device clock edges,
// then samples the device acknowledge. A single watchdog aborts on a silent device.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2400,
  parameter int START_TMO   = 360000,
  parameter int EDGE_TMO    = 48000,
  parameter int FILT        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int TMAX = (START_TMO > EDGE_TMO) ? START_TMO : EDGE_TMO;
  localparam int CMAX = (TMAX > INHIBIT_CYC) ? TMAX : INHIBIT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FILT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAIT_REL,
    S_FIN
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         lvl;
  logic [1:0][FW-1:0] fcnt;
  logic               clk_fall;
  logic               clk_lvl;
  logic               dat_lvl;

  state_t          state;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [3:0]      idx;
  logic [CW-1:0]   cnt;
  logic            wd_active;

  assign raw     = {ps2_dat_i, ps2_clk_i};
  assign clk_lvl = lvl[0];
  assign dat_lvl = lvl[1];

  // The one counter times the inhibit phase, then serves as the watchdog.
  assign wd_active = (state == S_REQ) || (state == S_BITS) ||
                     (state == S_ACK) || (state == S_WAIT_REL);

  // Frame bit driven after device falling edge n: data LSB first, parity, stop.
  function automatic logic frame_bit(input logic [3:0] n);
    logic b;
    b = 1'b1;
    if (n >= 4'd1 && n <= 4'd8) b = data_q[3'(n - 4'd1)];
    else if (n == 4'd9)         b = parity_q;
    return b;
  endfunction

  // Synchronize both lines, accept a new level only after FILT stable cycles,
  // and flag a clock falling edge in the cycle the filtered level drops.
  // NOTE: every register here uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '1;
      sync2    <= '1;
      lvl      <= '1;
      fcnt     <= '0;
      clk_fall <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      clk_fall <= lvl[0] && !sync2[0] && (fcnt[0] == FW'(FILT - 1));
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT - 1)) begin
          lvl[i]  <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Transfer sequencer with registered line drives and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 2'd0;
      // NOTE: the latched byte is cleared too, so an aborted command never reappears.
      data_q     <= '0;
      parity_q   <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      // NOTE: done defaults low here so it is a one-cycle pulse wherever it is set.
      done <= 1'b0;
      if (wd_active && cnt == '0) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        err        <= 2'd2;
        done       <= 1'b1;
        state      <= S_FIN;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_start) begin
              data_q     <= tx_data;
              parity_q   <= ~^tx_data;
              busy       <= 1'b1;
              err        <= 2'd0;
              idx        <= '0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= (INHIBIT_CYC == 1);
              cnt        <= CW'(INHIBIT_CYC - 1);
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            // Device edges seen here are our own inhibit and are ignored.
            if (cnt == '0) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              cnt        <= CW'(START_TMO);
              state      <= S_REQ;
            end else begin
              if (cnt == CW'(1)) ps2_dat_oe <= 1'b1;
              cnt <= cnt - CW'(1);
            end
          end
          S_REQ: begin
            if (clk_fall) begin
              idx        <= 4'd1;
              ps2_dat_oe <= ~frame_bit(4'd1);
              cnt        <= CW'(EDGE_TMO);
              state      <= S_BITS;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_BITS: begin
            if (clk_fall) begin
              idx        <= idx + 4'd1;
              ps2_dat_oe <= ~frame_bit(idx + 4'd1);
              cnt        <= CW'(EDGE_TMO);
              if (idx == 4'd9) state <= S_ACK;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_ACK: begin
            if (clk_fall) begin
              err   <= dat_lvl ? 2'd1 : 2'd0;
              idx   <= 4'd11;
              cnt   <= CW'(EDGE_TMO);
              state <= S_WAIT_REL;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_WAIT_REL: begin
            if (clk_lvl && dat_lvl) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else if (clk_fall) begin
              cnt <= CW'(EDGE_TMO);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_FIN: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model answers each request,
// expected results are queued at stimulus time and checked on every done pulse.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int STMO = 600;
  localparam int ETMO = 300;
  localparam int FL   = 8;
  localparam int HALF = 20;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_RESET  = 3;
  localparam int M_GLITCH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic       clk_line;
  logic       dat_line;

  // Open-drain bus: a line is high only when neither side pulls it low.
  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .START_TMO  (STMO),
    .EDGE_TMO   (ETMO),
    .FILT       (FL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (clk_line),
    .ps2_dat_i (dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [1:0] err;
    bit         frame;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;
  int          done_exp = 0;
  int          inh_len = 0;
  logic [10:0] cap = '1;   // [0] start, [8:1] data, [9] parity, [10] stop

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Device side of one transfer: measure inhibit, then clock out 11 edges
  // sampling the host data at the end of each low phase.
  task automatic dev_run(input int mode);
    int guard;
    cap     = '1;
    inh_len = 0;
    guard   = 0;
    while (!ps2_clk_oe && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    while (ps2_clk_oe && inh_len < 10 * INH) begin
      inh_len++;
      @(negedge clk);
    end
    cap[0] = dat_line;
    if (mode == M_SILENT) return;
    tick(30);
    for (int n = 1; n <= 11; n++) begin
      dev_clk = 1'b0;
      if (mode == M_RESET && n == 5) begin
        tick(5);
        reset_n = 1'b0;
        dev_clk = 1'b1;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", busy, 0);
        tick(3);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        return;
      end
      tick(HALF);
      if (n <= 10) cap[n] = dat_line;
      dev_clk = 1'b1;
      if (n == 10 && mode != M_NOACK) dev_dat = 1'b0;
      if (mode == M_GLITCH && n == 4) begin
        tick(8);
        dev_clk = 1'b0;
        tick(3);
        dev_clk  = 1'b1;
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(HALF - 12);
      end else begin
        tick(HALF);
      end
    end
    dev_dat = 1'b1;
    tick(HALF);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input logic [1:0] e);
    exp_t x;
    int   guard;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", busy, 1);
    if (mode != M_RESET) begin
      x.err   = e;
      x.frame = (mode != M_SILENT);
      x.data  = d;
      sb.push_back(x);
      done_exp++;
    end
    dev_run(mode);
    if (mode == M_RESET) begin
      tick(1);
      check("busy_after_reset", busy, 0);
    end else begin
      guard = 0;
      while (busy && guard < 4000) begin
        @(negedge clk);
        guard++;
      end
      check("idle_wait", busy, 0);
    end
    tick(5);
  endtask

  // Monitor: every done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        check("err", err, mon_e.err);
        check("clk_oe_at_done", ps2_clk_oe, 0);
        check("dat_oe_at_done", ps2_dat_oe, 0);
        check("inhibit_len", inh_len, INH);
        check("start_bit", cap[0], 0);
        if (mon_e.frame) begin
          check("data_bits", cap[8:1], mon_e.data);
          check("parity_bit", cap[9], ~^mon_e.data);
          check("odd_parity", ^cap[9:1], 1);
          check("stop_bit", cap[10], 1);
        end
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("done_single", done, 0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    tick(3);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    reset_n = 1'b1;
    tick(2);

    send(8'hED, M_ACK,    2'd0);
    send(8'h00, M_ACK,    2'd0);
    send(8'h5A, M_SILENT, 2'd2);
    send(8'hA5, M_NOACK,  2'd1);
    send(8'h12, M_ACK,    2'd0);
    send(8'h3C, M_RESET,  2'd0);
    send(8'hF4, M_ACK,    2'd0);
    send(8'hAA, M_GLITCH, 2'd0);

    tick(20);
    check("done_count", done_seen, done_exp);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
